// File: rtl/fetch_pkg.sv
// Shared types and defaults for the RV32I fetch sequencer.
package fetch_pkg;

    localparam int FETCH_XLEN            = 32;
    localparam int FETCH_TIMEOUT_CYCLES  = 255;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_WAIT   = 3'd2,
        ST_HOLD   = 3'd3,
        ST_HALTED = 3'd4
    } fetch_state_e;

endpackage

// File: rtl/fetch_timeout_counter.sv
// Down-counting imem response timer; expired marks the last allowed WAIT cycle.
module fetch_timeout_counter #(
    parameter int TIMEOUT_CYCLES = fetch_pkg::FETCH_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = LOAD_VAL;
        end else if (enable && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A count of one means this enabled cycle is the TIMEOUT_CYCLES-th one.
    assign expired = enable && (cnt_q == CW'(1));

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: drives PC updates, one outstanding imem fetch, and the decode handshake.
//
//  state     | meaning
//  ----------+-----------------------------------------------------------
//  ST_IDLE   | one cycle after reset, nothing asserted
//  ST_REQ    | presenting a fetch request at pc
//  ST_WAIT   | request accepted, waiting for imem_rvalid (timed)
//  ST_HOLD   | instruction held for decode until instr_ready or redirect
//  ST_HALTED | halt or timeout; only reset leaves
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int XLEN           = FETCH_XLEN,
    parameter int TIMEOUT_CYCLES = FETCH_TIMEOUT_CYCLES
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc,
    output logic            pc_enable,
    output logic            pc_jump,
    output logic [XLEN-1:0] pc_jump_address,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_addr,
    input  logic            halt_req,
    output logic            halted,
    output logic            fetch_fault
);

    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    fetch_state_e    state_q, state_d;
    logic            instr_valid_q, instr_valid_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] instr_pc_q, instr_pc_d;
    logic            halted_q, halted_d;
    logic            fetch_fault_q, fetch_fault_d;
    logic            kill_q, kill_d;
    logic [XLEN-1:0] pending_q, pending_d;
    logic            halt_seen_q, halt_seen_d;

    logic            tmr_clear;
    logic            tmr_enable;
    logic            tmr_expired;
    logic [XLEN-1:0] redirect_tgt;

    assign redirect_tgt = redirect_addr & ALIGN_MASK;

    fetch_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (tmr_clear),
        .enable (tmr_enable),
        .expired(tmr_expired)
    );

    always_comb begin
        state_d         = state_q;
        instr_valid_d   = instr_valid_q;
        instr_d         = instr_q;
        instr_pc_d      = instr_pc_q;
        halted_d        = halted_q;
        fetch_fault_d   = fetch_fault_q;
        kill_d          = kill_q;
        pending_d       = pending_q;
        halt_seen_d     = halt_seen_q | halt_req;
        pc_enable       = 1'b0;
        pc_jump         = 1'b0;
        pc_jump_address = '0;
        imem_req_valid  = 1'b0;
        tmr_clear       = 1'b0;
        tmr_enable      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                state_d = ST_REQ;
            end
            ST_REQ: begin
                if (redirect_valid) begin
                    pc_enable       = 1'b1;
                    pc_jump         = 1'b1;
                    pc_jump_address = redirect_tgt;
                end else if (halt_seen_d) begin
                    // Request withheld so no fetch is left dangling in imem.
                    state_d  = ST_HALTED;
                    halted_d = 1'b1;
                end else begin
                    imem_req_valid = 1'b1;
                    if (imem_req_ready) begin
                        state_d   = ST_WAIT;
                        tmr_clear = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                tmr_enable = 1'b1;
                if (imem_rvalid) begin
                    state_d   = ST_REQ;
                    kill_d    = 1'b0;
                    pc_enable = 1'b1;
                    if (redirect_valid) begin
                        pc_jump         = 1'b1;
                        pc_jump_address = redirect_tgt;
                    end else if (kill_q) begin
                        pc_jump         = 1'b1;
                        pc_jump_address = pending_q;
                    end else begin
                        state_d       = ST_HOLD;
                        instr_d       = imem_rdata;
                        instr_pc_d    = pc;
                        instr_valid_d = 1'b1;
                    end
                end else if (tmr_expired) begin
                    state_d       = ST_HALTED;
                    fetch_fault_d = 1'b1;
                    halted_d      = 1'b1;
                end else if (redirect_valid) begin
                    kill_d    = 1'b1;
                    pending_d = redirect_tgt;
                end
            end
            ST_HOLD: begin
                if (redirect_valid) begin
                    state_d         = ST_REQ;
                    instr_valid_d   = 1'b0;
                    pc_enable       = 1'b1;
                    pc_jump         = 1'b1;
                    pc_jump_address = redirect_tgt;
                end else if (instr_ready) begin
                    state_d       = ST_REQ;
                    instr_valid_d = 1'b0;
                end
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            instr_valid_q <= 1'b0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            halted_q      <= 1'b0;
            fetch_fault_q <= 1'b0;
            kill_q        <= 1'b0;
            pending_q     <= '0;
            halt_seen_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            instr_valid_q <= instr_valid_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            halted_q      <= halted_d;
            fetch_fault_q <= fetch_fault_d;
            kill_q        <= kill_d;
            pending_q     <= pending_d;
            halt_seen_q   <= halt_seen_d;
        end
    end

    assign instr_valid = instr_valid_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign halted      = halted_q;
    assign fetch_fault = fetch_fault_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a PC register model and a hand-driven imem.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic        pc_enable;
    logic        pc_jump;
    logic [31:0] pc_jump_address;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        redirect_valid;
    logic [31:0] redirect_addr;
    logic        halt_req;
    logic        halted;
    logic        fetch_fault;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    fetch_sequencer #(
        .XLEN          (32),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .pc             (pc),
        .pc_enable      (pc_enable),
        .pc_jump        (pc_jump),
        .pc_jump_address(pc_jump_address),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .halt_req       (halt_req),
        .halted         (halted),
        .fetch_fault    (fetch_fault)
    );

    // External program counter behaviour.
    always @(posedge clk) begin
        if (!reset)         pc <= 32'h0;
        else if (pc_enable) pc <= pc_jump ? pc_jump_address : pc + 32'd4;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset          = 1'b0;
        imem_req_ready = 1'b1;
        imem_rvalid    = 1'b0;
        imem_rdata     = 32'h0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_addr  = 32'h0;
        halt_req       = 1'b0;

        // Reset low for two cycles.
        cyc(); cyc();
        chk("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_halted", {31'b0, halted}, 32'd0);
        chk("rst_fault", {31'b0, fetch_fault}, 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_instr_pc", instr_pc, 32'h0);
        chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);

        // Test 1: IDLE, REQ at pc=0, reply one cycle after accept.
        reset = 1'b1;
        #1;
        chk("idle_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("idle_pc_enable", {31'b0, pc_enable}, 32'd0);
        cyc();
        chk("t1_req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("t1_req_pc", pc, 32'h0);
        cyc();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0000_0013;
        #1;
        chk("t1_rsp_pc_enable", {31'b0, pc_enable}, 32'd1);
        chk("t1_rsp_pc_jump", {31'b0, pc_jump}, 32'd0);
        chk("t1_rsp_jump_addr", pc_jump_address, 32'h0);
        chk("t1_rsp_req_valid", {31'b0, imem_req_valid}, 32'd0);
        cyc();
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        #1;
        chk("t1_instr_valid", {31'b0, instr_valid}, 32'd1);
        chk("t1_instr", instr, 32'h0000_0013);
        chk("t1_instr_pc", instr_pc, 32'h0);
        chk("t1_pc_after", pc, 32'h4);

        // Test 2: decode stalls for five cycles in HOLD.
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("t2_hold_valid", {31'b0, instr_valid}, 32'd1);
            chk("t2_hold_instr", instr, 32'h0000_0013);
            chk("t2_hold_req", {31'b0, imem_req_valid}, 32'd0);
            chk("t2_hold_pc_en", {31'b0, pc_enable}, 32'd0);
        end
        chk("t2_pc_once", pc, 32'h4);
        instr_ready = 1'b1;
        cyc();
        instr_ready = 1'b0;
        #1;
        chk("t2_consumed", {31'b0, instr_valid}, 32'd0);
        chk("t2_next_req", {31'b0, imem_req_valid}, 32'd1);
        chk("t2_next_req_pc", pc, 32'h4);

        // Test 3: redirect in WAIT, response three cycles later on the last WAIT cycle.
        cyc();
        redirect_valid = 1'b1;
        redirect_addr  = 32'h100;
        #1;
        chk("t3_wait_pc_en", {31'b0, pc_enable}, 32'd0);
        cyc();
        redirect_valid = 1'b0;
        cyc();
        cyc();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        #1;
        chk("t3_kill_pc_en", {31'b0, pc_enable}, 32'd1);
        chk("t3_kill_jump", {31'b0, pc_jump}, 32'd1);
        chk("t3_kill_addr", pc_jump_address, 32'h100);
        cyc();
        imem_rvalid = 1'b0;
        #1;
        chk("t3_no_instr", {31'b0, instr_valid}, 32'd0);
        chk("t3_no_fault", {31'b0, fetch_fault}, 32'd0);
        chk("t3_pc", pc, 32'h100);
        chk("t3_req", {31'b0, imem_req_valid}, 32'd1);

        // Test 4: redirect coincident with rvalid.
        cyc();
        imem_rvalid    = 1'b1;
        imem_rdata     = 32'h1234_5678;
        redirect_valid = 1'b1;
        redirect_addr  = 32'h40;
        #1;
        chk("t4_pc_en", {31'b0, pc_enable}, 32'd1);
        chk("t4_jump", {31'b0, pc_jump}, 32'd1);
        chk("t4_addr", pc_jump_address, 32'h40);
        cyc();
        imem_rvalid    = 1'b0;
        redirect_valid = 1'b0;
        #1;
        chk("t4_no_instr", {31'b0, instr_valid}, 32'd0);
        chk("t4_pc", pc, 32'h40);

        // Test 5: misaligned redirect while in REQ.
        redirect_valid = 1'b1;
        redirect_addr  = 32'h203;
        #1;
        chk("t5_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("t5_jump", {31'b0, pc_jump}, 32'd1);
        chk("t5_addr", pc_jump_address, 32'h200);
        cyc();
        redirect_valid = 1'b0;
        #1;
        chk("t5_pc", pc, 32'h200);
        chk("t5_req_again", {31'b0, imem_req_valid}, 32'd1);

        // Test 6: no response, timeout after four WAIT cycles.
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("t6_pre_fault", {31'b0, fetch_fault}, 32'd0);
            chk("t6_pre_halted", {31'b0, halted}, 32'd0);
        end
        cyc();
        chk("t6_fault", {31'b0, fetch_fault}, 32'd1);
        chk("t6_halted", {31'b0, halted}, 32'd1);
        redirect_valid = 1'b1;
        redirect_addr  = 32'h80;
        #1;
        chk("t6_halt_pc_en", {31'b0, pc_enable}, 32'd0);
        chk("t6_halt_req", {31'b0, imem_req_valid}, 32'd0);
        cyc(); cyc();
        redirect_valid = 1'b0;
        chk("t6_fault_sticky", {31'b0, fetch_fault}, 32'd1);
        chk("t6_halted_sticky", {31'b0, halted}, 32'd1);

        reset = 1'b0;
        cyc();
        chk("t6_rst_fault", {31'b0, fetch_fault}, 32'd0);
        chk("t6_rst_halted", {31'b0, halted}, 32'd0);

        // halt_req pulsed during IDLE is remembered and honoured at REQ.
        reset    = 1'b1;
        halt_req = 1'b1;
        cyc();
        halt_req = 1'b0;
        #1;
        chk("t7_req_blocked", {31'b0, imem_req_valid}, 32'd0);
        chk("t7_pc_en", {31'b0, pc_enable}, 32'd0);
        cyc();
        chk("t7_halted", {31'b0, halted}, 32'd1);
        chk("t7_no_fault", {31'b0, fetch_fault}, 32'd0);
        chk("t7_pc", pc, 32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
